// File: rtl/blit_bus_responder.sv
// Target end of the blitter bus: grants the bus, runs one
// memory access per mreq and returns a single-cycle ack.
module blit_bus_responder #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busreq,
  input  logic        hipri_req,
  input  logic        mreq,
  input  logic        read,
  input  logic [3:0]  width,
  input  logic        justify,
  input  logic [23:0] blit_addr,
  output logic        blit_back,
  output logic        ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_be,
  input  logic        mem_rdy,
  output logic        granted_hp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS,
    S_ACK,
    S_HP
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [20:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic        blit_back_q, blit_back_d;
  logic        ack_q, ack_d;
  logic        mem_cs_q, mem_cs_d;
  logic        granted_hp_q, granted_hp_d;

  logic [7:0]  lane_mask;
  logic [2:0]  lane_low;
  logic [2:0]  lane_base;
  logic [7:0]  be_calc;

  // Byte-lane enables for the request currently on the bus
  always_comb begin
    lane_mask = 8'h01;
    lane_low  = 3'b000;
    priority case (1'b1)
      width[3]: begin
        lane_mask = 8'hFF;
        lane_low  = 3'b111;
      end
      width[2]: begin
        lane_mask = 8'h0F;
        lane_low  = 3'b011;
      end
      width[1]: begin
        lane_mask = 8'h03;
        lane_low  = 3'b001;
      end
      default: begin
        lane_mask = 8'h01;
        lane_low  = 3'b000;
      end
    endcase
    lane_base = justify ? (blit_addr[2:0] & ~lane_low) : 3'b000;
    be_calc   = lane_mask << lane_base;
  end

  // Next-state, access latches and output decode
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_we_d   = mem_we_q;
    case (state_q)
      S_IDLE: begin
        if (hipri_req)   state_d = S_HP;
        else if (busreq) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (mreq) begin
          mem_addr_d = blit_addr[23:3];
          mem_be_d   = be_calc;
          mem_we_d   = ~read;
          wait_d     = WS;
          state_d    = S_ACCESS;
        end else if (hipri_req) begin
          state_d = S_HP;
        end else if (!busreq) begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        else if (mem_rdy)   state_d = S_ACK;
      end
      S_ACK: begin
        if (hipri_req)   state_d = S_HP;
        else if (busreq) state_d = S_GRANT;
        else             state_d = S_IDLE;
      end
      S_HP: begin
        if (!hipri_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    blit_back_d  = (state_d == S_GRANT) ||
                   (state_d == S_ACCESS) ||
                   (state_d == S_ACK);
    mem_cs_d     = (state_d == S_ACCESS);
    ack_d        = (state_d == S_ACK);
    granted_hp_d = (state_d == S_HP);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_q       <= 4'd0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_we_q     <= 1'b0;
      blit_back_q  <= 1'b0;
      ack_q        <= 1'b0;
      mem_cs_q     <= 1'b0;
      granted_hp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_we_q     <= mem_we_d;
      blit_back_q  <= blit_back_d;
      ack_q        <= ack_d;
      mem_cs_q     <= mem_cs_d;
      granted_hp_q <= granted_hp_d;
    end
  end

  assign blit_back  = blit_back_q;
  assign ack        = ack_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign granted_hp = granted_hp_q;

endmodule
